// File: rtl/wb_master_adapter.sv
// Wishbone classic single-transfer master bridging the core load/store port onto the NoC bus.
// Optional watchdog on the slave response enabled with `define WBM_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no transfer outstanding, accepting cpu_req_i
// S_WAIT   | cyc/stb asserted, bus fields frozen, waiting for ack/err
module wb_master_adapter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic [DATA_W/8-1:0] cpu_be_i,
    output logic                cpu_busy_o,
    output logic                cpu_done_o,
    output logic                cpu_err_o,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]          r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [DATA_W/8-1:0] r_sel;
    logic                r_we;
    logic                r_cyc;
    logic                r_stb;

    logic                w_resp;
    logic                w_tmo_hit;
    logic [1:0]          w_unused_addr_lo;

    // Byte offset is dropped: the bus is word addressed, lanes come from sel.
    assign w_unused_addr_lo = cpu_addr_i[1:0];
    assign w_resp           = wb_ack_i | wb_err_i;

`ifdef WBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;

    // Hit when this silent cycle is the TIMEOUT_CYCLES-th one spent in S_WAIT.
    assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_tmo_cnt <= '0;
        end else if (!w_resp && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (cpu_req_i) begin
                        r_adr   <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
                        r_dat   <= cpu_wdata_i;
                        r_sel   <= cpu_be_i;
                        r_we    <= cpu_we_i;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_resp) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= wb_err_i;
                        // Error beats a simultaneous ack: read data is not taken.
                        if (!wb_err_i && !r_we) begin
                            r_rdata <= wb_dat_i;
                        end
                        r_state <= S_IDLE;
                    end else if (w_tmo_hit) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_busy_o  = r_busy;
    assign cpu_done_o  = r_done;
    assign cpu_err_o   = r_err;
    assign cpu_rdata_o = r_rdata;
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign wb_sel_o    = r_sel;
    assign wb_we_o     = r_we;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_stb;

endmodule

// File: tb/tb_wb_master_adapter.sv
// Randomized bench for wb_master_adapter: transaction-level reference model of the bus master.
// Timeout scenarios are exercised when built with WBM_TIMEOUT_EN (DUT TIMEOUT_CYCLES = 4).
module tb_wb_master_adapter;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [3:0]  cpu_be_i;
    logic        cpu_busy_o;
    logic        cpu_done_o;
    logic        cpu_err_o;
    logic [31:0] cpu_rdata_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: last successfully read word, held across transfers.
    logic [31:0] m_rdata;

    wb_master_adapter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cpu_req_i(cpu_req_i),
        .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i),
        .cpu_be_i(cpu_be_i),
        .cpu_busy_o(cpu_busy_o),
        .cpu_done_o(cpu_done_o),
        .cpu_err_o(cpu_err_o),
        .cpu_rdata_o(cpu_rdata_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_quiet(input string tag);
        check({tag, " cyc"},  {31'd0, wb_cyc_o},   32'd0);
        check({tag, " stb"},  {31'd0, wb_stb_o},   32'd0);
        check({tag, " busy"}, {31'd0, cpu_busy_o}, 32'd0);
        check({tag, " done"}, {31'd0, cpu_done_o}, 32'd0);
        check({tag, " err"},  {31'd0, cpu_err_o},  32'd0);
        check({tag, " rdata"}, cpu_rdata_o, m_rdata);
    endtask

    task automatic check_bus(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        check({tag, " cyc"},  {31'd0, wb_cyc_o},   32'd1);
        check({tag, " stb"},  {31'd0, wb_stb_o},   32'd1);
        check({tag, " busy"}, {31'd0, cpu_busy_o}, 32'd1);
        check({tag, " done"}, {31'd0, cpu_done_o}, 32'd0);
        check({tag, " adr"},  wb_adr_o, addr & 32'hFFFF_FFFC);
        check({tag, " dat"},  wb_dat_o, wdata);
        check({tag, " sel"},  {28'd0, wb_sel_o}, {28'd0, be});
        check({tag, " we"},   {31'd0, wb_we_o},  {31'd0, we});
    endtask

    // One transfer: slave answers in the lat-th WAIT cycle (lat>=1); lat=0 means never
    // answer (only meaningful with the watchdog). junk_req pulses a foreign request mid-wait.
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int lat,
                        input logic s_ack, input logic s_err, input logic [31:0] s_dat,
                        input logic junk_req);
        int  waits;
        logic exp_err;
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        cpu_be_i    = be;
        tick();
        cpu_req_i   = 1'b0;
        cpu_we_i    = $urandom_range(0, 1);
        cpu_addr_i  = $urandom;
        cpu_wdata_i = $urandom;
        cpu_be_i    = 4'($urandom);
        waits = (lat == 0) ? TMO : lat;
        for (int c = 1; c <= waits; c++) begin
            check_bus({tag, " wait"}, we, addr, wdata, be);
            if (c == waits && lat != 0) begin
                wb_ack_i = s_ack;
                wb_err_i = s_err;
                wb_dat_i = s_dat;
                cpu_req_i = 1'b0;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = $urandom;
                cpu_req_i = junk_req && (c == 1);
            end
            tick();
        end
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        cpu_req_i = 1'b0;
        exp_err = (lat == 0) ? 1'b1 : s_err;
        if (lat != 0 && !s_err && !we) m_rdata = s_dat;
        check({tag, " done cyc"},  {31'd0, wb_cyc_o},   32'd0);
        check({tag, " done stb"},  {31'd0, wb_stb_o},   32'd0);
        check({tag, " done busy"}, {31'd0, cpu_busy_o}, 32'd0);
        check({tag, " done"},      {31'd0, cpu_done_o}, 32'd1);
        check({tag, " done err"},  {31'd0, cpu_err_o},  {31'd0, exp_err});
        check({tag, " rdata"},     cpu_rdata_o, m_rdata);
        tick();
        check_idle_quiet({tag, " after"});
    endtask

    initial begin
        logic [31:0] a, d;
        logic        w, e;
        int          l;

        rst_i = 1'b1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_be_i = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        m_rdata = '0;
        tick();
        tick();
        check_idle_quiet("reset");
        check("reset adr", wb_adr_o, 32'd0);
        check("reset dat", wb_dat_o, 32'd0);
        check("reset sel", {28'd0, wb_sel_o}, 32'd0);
        check("reset we",  {31'd0, wb_we_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        // Directed cases from the plan.
        xfer("write", 1'b1, 32'h0000_1006, 32'hA5A5_0F0F, 4'hF, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        xfer("read", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        tick(); tick();
        check("read held", cpu_rdata_o, 32'h1234_5678);
        xfer("ackerr", 1'b0, 32'h0000_0020, 32'h0, 4'hF, 3, 1'b1, 1'b1, 32'hFFFF_0000, 1'b0);
        xfer("erronly", 1'b0, 32'h0000_0024, 32'h0, 4'h3, 1, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0);
        xfer("junkreq", 1'b1, 32'h0000_0103, 32'h1111_2222, 4'h5, 3, 1'b1, 1'b0, 32'h0, 1'b1);

        // Slave responses in idle must not produce a completion.
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check_idle_quiet("idle ack");

        // Back-to-back: request held high across the done cycle.
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0200;
        cpu_wdata_i = 32'hAAAA_0001; cpu_be_i = 4'hF;
        tick();
        check_bus("b2b first", 1'b1, 32'h0000_0200, 32'hAAAA_0001, 4'hF);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("b2b gap cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("b2b gap done", {31'd0, cpu_done_o}, 32'd1);
        cpu_addr_i = 32'h0000_0305; cpu_wdata_i = 32'hBBBB_0002; cpu_be_i = 4'hC;
        tick();
        cpu_req_i = 1'b0;
        check_bus("b2b second", 1'b1, 32'h0000_0305, 32'hBBBB_0002, 4'hC);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("b2b2 done", {31'd0, cpu_done_o}, 32'd1);
        tick();
        check_idle_quiet("b2b end");

`ifdef WBM_TIMEOUT_EN
        xfer("timeout", 1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        xfer("post tmo", 1'b0, 32'h0000_0404, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h7777_8888, 1'b0);
        xfer("ack at expiry", 1'b0, 32'h0000_0408, 32'h0, 4'hF, TMO, 1'b1, 1'b0, 32'h9999_AAAA, 1'b0);
`endif

        // Randomized transfers against the model.
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            d = $urandom;
            l = $urandom_range(1, TMO);
            e = ($urandom_range(0, 4) == 0);
            xfer("rand", w, a, d, 4'($urandom), l, ~e | 1'($urandom_range(0, 1)), e,
                 $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset while waiting: bus released immediately, data cleared, no completion.
        xfer("pre rst", 1'b0, 32'h0000_0500, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h5555_6666, 1'b0);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0600; cpu_be_i = 4'hF;
        tick();
        cpu_req_i = 1'b0;
        check_bus("rst wait", 1'b0, 32'h0000_0600, cpu_wdata_i, 4'hF);
        #2;
        rst_i = 1'b1;
        #1;
        m_rdata = '0;
        check("rst async cyc",  {31'd0, wb_cyc_o},   32'd0);
        check("rst async stb",  {31'd0, wb_stb_o},   32'd0);
        check("rst async busy", {31'd0, cpu_busy_o}, 32'd0);
        check("rst async rdata", cpu_rdata_o, 32'd0);
        wb_ack_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        wb_ack_i = 1'b0;
        check_idle_quiet("rst after");
        tick();
        check_idle_quiet("rst after2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_master_adapter.md
Name: wb_master_adapter

Overview:
- Wishbone classic single-transfer master (initiator) bridging the RV32I core's simple load/store request port onto the NoC Wishbone bus.
- Drives the same wb_adr/wb_dat/wb_sel/wb_we/wb_cyc/wb_stb protocol that the peripheral slave adapters (LED matrix, RAM) respond to.
- Holds one outstanding transfer; returns read data, a one-cycle done pulse and an error flag to the core.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; wb_sel width = DATA_W/8.
- TIMEOUT_CYCLES, 255, max cycles in WAIT_ACK before abort (used only with WBM_TIMEOUT_EN); must be >= 1.

Ports:
- clk_i input 1: clock, all logic rising-edge.
- rst_i input 1: asynchronous reset, active-high.
- cpu_req_i input 1: request strobe; accepted only when cpu_busy_o=0.
- cpu_we_i input 1: 1 = write, 0 = read.
- cpu_addr_i input ADDR_W: byte address.
- cpu_wdata_i input DATA_W: write data.
- cpu_be_i input DATA_W/8: byte enables.
- cpu_busy_o output 1: transfer in progress.
- cpu_done_o output 1: one-cycle completion pulse.
- cpu_err_o output 1: valid with cpu_done_o; 1 = bus error/timeout.
- cpu_rdata_o output DATA_W: read data, held until next completion.
- wb_adr_o output ADDR_W: word-aligned address.
- wb_dat_o output DATA_W: write data.
- wb_sel_o output DATA_W/8: byte select.
- wb_we_o output 1: write enable.
- wb_cyc_o output 1: cycle valid.
- wb_stb_o output 1: strobe.
- wb_dat_i input DATA_W: slave read data.
- wb_ack_i input 1: slave acknowledge.
- wb_err_i input 1: slave error.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate): state=IDLE; cyc/stb/we=0; adr/dat/sel=0; busy/done/err=0; rdata=0; timeout counter=0.
- States:
  - IDLE: if cpu_req_i=1, latch wb_adr_o={cpu_addr_i[ADDR_W-1:2],2'b00}, wb_dat_o, wb_sel_o, wb_we_o; set cyc=stb=1 and busy=1; go to WAIT_ACK. cyc/stb are first visible in the cycle after the request edge.
  - WAIT_ACK: the wb_adr/dat/sel/we outputs are frozen. On wb_ack_i or wb_err_i:
    - clear cyc/stb/we and busy;
    - pulse done=1 for exactly 1 cycle;
    - err=wb_err_i;
    - on a read ack with no err, capture rdata=wb_dat_i; on error, rdata is unchanged;
    - go to IDLE.
- Latency: request at edge N, cyc/stb from N+1. With a slave ack at edge N+k, done=1 in cycle N+k+1 and cyc=0 in the same cycle. Minimum round trip is 2 cycles.
- Back-to-back: a new cpu_req_i is accepted in the done cycle, since busy=0 there. That gives cyc low for exactly 1 cycle between transfers.
- cpu_req_i while busy=1 is ignored, not queued.
- ack and err in the same cycle: err wins (err=1, rdata unchanged).
- ack/err while in IDLE: ignored, no done pulse.
- wb_dat_i is sampled only on an ack edge.
- done and err are zero in every cycle except the completion cycle.
- Reset mid-transfer: cyc/stb drop asynchronously. No done pulse is generated for the aborted transfer.

Optional Feature:
- Macro WBM_TIMEOUT_EN.
- When defined:
  - counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle with no ack/err;
  - when the count reaches TIMEOUT_CYCLES with still no ack/err: abort, cyc/stb=0, done=1, err=1, rdata unchanged, go to IDLE;
  - ack/err arriving in the expiry cycle wins over timeout.
- When undefined: no counter logic; the master waits in WAIT_ACK indefinitely.

Test Plan:
- Write: req with addr=0x0000_1006, wdata=0xA5A5_0F0F, be=4'hF, we=1; slave acks 2 cycles after stb. Expect:
  - adr_o=0x0000_1004, dat_o=0xA5A5_0F0F, sel_o=4'hF, we_o=1 held stable;
  - done=1, err=0 one cycle after ack; cyc=0 in the same cycle.
- Read: req with addr=0x10, we=0; slave drives dat_i=0x1234_5678 with ack. Expect rdata=0x1234_5678 at done, held through a following idle period.
- Error: slave asserts ack and err together on a read. Expect done=1, err=1, rdata unchanged from its prior value.
- Back-to-back: req held high continuously for two writes. Expect cyc low for exactly 1 cycle between them; a req pulse during busy produces no extra transfer.
- Timeout (WBM_TIMEOUT_EN, TIMEOUT_CYCLES=4), slave never acks. Expect cyc to fall and done=1, err=1 after 4 WAIT_ACK cycles; then a new req is accepted normally.
- Reset: assert rst_i during WAIT_ACK. Expect cyc=stb=busy=0 immediately, no done pulse, and rdata=0.
